multicycle_ctrl_fsm: RTL and testbench
======================================

# multicycle_ctrl_fsm

Parametrised multicycle MIPS control unit: owns the control state register, sequences fetch/decode/execute/memory/writeback, and drives every datapath enable and mux select. It replaces the externally-sequenced decoder. New capabilities:
- branches (BEQ/BNE) and jumps (J);
- configurable multi-cycle memory latency;
- a pipeline-freeze stall input;
- an illegal-opcode halt.

It sits between the instruction register (opcode/funct) and the datapath; `alu_op` feeds the existing ALU control decoder.

## Interface
- MEM_LATENCY, 1, cycles per memory read (instruction fetch and load); legal range 1..15.
- CNT_W, 4, width of the internal wait counter; must satisfy 2^CNT_W > MEM_LATENCY.
- clk  in  1  single clock; all state changes on the rising edge.
- rstb  in  1  synchronous, active-low reset.
- stall  in  1  freeze: holds the state and wait counter, and forces all write enables to 0.
- opcode  in  6  instr[31:26] from the IR.
- state  out  4  current state encoding.
- halted  out  1  high in HALT.
- pc_write, pc_write_cond, ir_write, mdr_write, reg_write, mem_wr_ena  out  1 each  write enables.
- branch_ne  out  1  1 means a branch is taken when the ALU zero flag is 0 (BNE).
- alu_src_a  out  1  0 selects PC, 1 selects register A.
- alu_src_b  out  2  00 selects B, 01 selects constant 4, 10 selects sign-extended immediate, 11 selects sign-extended immediate << 2.
- alu_op  out  2  00 add, 01 subtract, 10 decode funct, 11 decode opcode (I-type).
- pc_src  out  2  00 selects the ALU result, 01 selects ALUOut, 10 selects the jump target.
- i_or_d, reg_dst, mem_to_reg  out  1 each  mux selects.

## Operation
- Opcodes decoded: R 000000, J 000010, BEQ 000100, BNE 000101, ADDI 001000, SLTI 001010, ANDI 001100, ORI 001101, XORI 001110, LW 100011, SW 101011. Any other opcode is illegal.
- Outputs are Moore-style decodes of `state`, plus `wait_cnt`, plus `opcode` where stated below. Any select not listed for a state is 0.
- **FETCH (0)**
  - Drives i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - wait_cnt counts 0..MEM_LATENCY-1.
  - On the final count cycle only, ir_write=1 and pc_write=1, then the FSM moves to DECODE.
- **DECODE (1)**
  - Drives alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes the branch target).
  - Next state by opcode: R goes to EXECUTE; ADDI/SLTI/ANDI/ORI/XORI go to EXECUTE_IMM; LW/SW go to MEMADDR; BEQ/BNE go to BRANCH; J goes to JUMP; any illegal opcode goes to HALT.
- **EXECUTE (2):** alu_src_a=1, alu_src_b=00, alu_op=10. Next state ALU_WRITEBACK.
- **EXECUTE_IMM (4):** alu_src_a=1, alu_src_b=10, alu_op=11. Next state ALU_WRITEBACK.
- **ALU_WRITEBACK (3):** reg_write=1, mem_to_reg=0, reg_dst=1 if opcode==R else 0. Next state FETCH.
- **MEMADDR (5):** alu_src_a=1, alu_src_b=10, alu_op=00. Next state MEMREAD for LW, MEMWRITE for SW.
- **MEMREAD (6):** i_or_d=1, with the same wait_cnt sequencing as FETCH. On the final cycle mdr_write=1, then the FSM moves to MEM_WRITEBACK.
- **MEM_WRITEBACK (7):** reg_write=1, mem_to_reg=1, reg_dst=0. Next state FETCH.
- **MEMWRITE (8):** i_or_d=1, mem_wr_ena=1 for exactly one cycle. Next state FETCH.
- **BRANCH (9)**
  - Drives alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_write_cond=1.
  - branch_ne = (opcode==BNE).
  - Next state FETCH.
- **JUMP (10):** pc_write=1, pc_src=10. Next state FETCH.
- **HALT (15):** all enables 0 and halted=1. The FSM stays in HALT until reset.
- **Wait counter:** cleared on every state transition; incremented only in FETCH/MEMREAD while not stalled; saturates at MEM_LATENCY-1.
- **Stall:**
  - The state and counter hold.
  - pc_write, pc_write_cond, ir_write, mdr_write, reg_write and mem_wr_ena are all 0.
  - Mux selects keep their per-state values.
  - Stall has no effect in HALT.

## Timing
- **Reset:** rstb=0 at a rising edge sets state=FETCH, wait_cnt=0, halted=0. While rstb=0, all write enables are forced to 0. This applies mid-instruction, including mid-memory-wait and in HALT.
- **Cycles per instruction with no stall (L = MEM_LATENCY):**
  - R and I-ALU: L+3.
  - LW: 2L+3.
  - SW: L+3.
  - BEQ, BNE, J: L+2.
- Each stall cycle adds exactly one cycle to the instruction.
- Every write enable is high for exactly one unstalled cycle per instruction, as defined above.
- A stall asserted on the final wait cycle defers ir_write/mdr_write to the first unstalled cycle.
- opcode must be stable from the cycle after the ir_write edge until the instruction returns to FETCH.

## Test plan
- **Reset and R-type:** rstb=0 for 2 cycles, then an R opcode with L=1. Required: state sequence 0,1,2,3,0; reg_write=1 in state 3 with reg_dst=1; 4 cycles total.
- **LW with L=3:** required sequence FETCH×3, DECODE, MEMADDR, MEMREAD×3, MEM_WRITEBACK (9 cycles). ir_write is high only on the 3rd FETCH cycle; mdr_write is high only on the 3rd MEMREAD cycle.
- **BNE, then J:** BNE gives pc_write_cond=1, branch_ne=1, pc_src=01, alu_op=01. J gives pc_write=1, pc_src=10. Each takes L+2 cycles.
- **Stall:** stall=1 for 2 cycles in MEMWRITE. Required: mem_wr_ena=0 while stalled, then exactly one high cycle, then FETCH.
- **Illegal opcode 111111:** DECODE goes to HALT; halted=1 and all enables 0 for 10+ cycles. rstb=0 returns the FSM to FETCH.
- **Reset mid-wait:** rstb=0 during FETCH with wait_cnt=1 and L=3. Required: next state FETCH, wait_cnt=0, and no ir_write until 3 full FETCH cycles have elapsed.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multicycle MIPS control unit with memory-latency wait, stall and halt
module multicycle_ctrl_fsm #(
  parameter int MEM_LATENCY = 1,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       stall,
  input  logic [5:0] opcode,
  output logic [3:0] state,
  output logic       halted,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       reg_write,
  output logic       mem_wr_ena,
  output logic       branch_ne,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       i_or_d,
  output logic       reg_dst,
  output logic       mem_to_reg
);

  typedef enum logic [3:0] {
    S_FETCH       = 4'd0,
    S_DECODE      = 4'd1,
    S_EXECUTE     = 4'd2,
    S_ALU_WB      = 4'd3,
    S_EXECUTE_IMM = 4'd4,
    S_MEMADDR     = 4'd5,
    S_MEMREAD     = 4'd6,
    S_MEM_WB      = 4'd7,
    S_MEMWRITE    = 4'd8,
    S_BRANCH      = 4'd9,
    S_JUMP        = 4'd10,
    S_HALT        = 4'd15
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wait_done;
  logic             en_ok;
  logic             pc_write_raw, pc_write_cond_raw, ir_write_raw;
  logic             mdr_write_raw, reg_write_raw, mem_wr_ena_raw;

  assign wait_done = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else if (!stall) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter only advances while waiting on memory; any transition clears it.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_FETCH: begin
        if (wait_done) state_d = S_DECODE;
        else           cnt_d   = cnt_q + 1'b1;
      end
      S_DECODE: begin
        case (opcode)
          OP_R:                                      state_d = S_EXECUTE;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: state_d = S_EXECUTE_IMM;
          OP_LW, OP_SW:                              state_d = S_MEMADDR;
          OP_BEQ, OP_BNE:                            state_d = S_BRANCH;
          OP_J:                                      state_d = S_JUMP;
          default:                                   state_d = S_HALT;
        endcase
      end
      S_EXECUTE, S_EXECUTE_IMM: state_d = S_ALU_WB;
      S_MEMADDR: state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (wait_done) state_d = S_MEM_WB;
        else           cnt_d   = cnt_q + 1'b1;
      end
      S_ALU_WB, S_MEM_WB, S_MEMWRITE, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_comb begin
    pc_write_raw      = 1'b0;
    pc_write_cond_raw = 1'b0;
    ir_write_raw      = 1'b0;
    mdr_write_raw     = 1'b0;
    reg_write_raw     = 1'b0;
    mem_wr_ena_raw    = 1'b0;
    branch_ne         = 1'b0;
    alu_src_a         = 1'b0;
    alu_src_b         = 2'b00;
    alu_op            = 2'b00;
    pc_src            = 2'b00;
    i_or_d            = 1'b0;
    reg_dst           = 1'b0;
    mem_to_reg        = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b    = 2'b01;
        ir_write_raw = wait_done;
        pc_write_raw = wait_done;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_EXECUTE_IMM: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
      end
      S_ALU_WB: begin
        reg_write_raw = 1'b1;
        reg_dst       = (opcode == OP_R);
      end
      S_MEMADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMREAD: begin
        i_or_d        = 1'b1;
        mdr_write_raw = wait_done;
      end
      S_MEM_WB: begin
        reg_write_raw = 1'b1;
        mem_to_reg    = 1'b1;
      end
      S_MEMWRITE: begin
        i_or_d         = 1'b1;
        mem_wr_ena_raw = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a         = 1'b1;
        alu_op            = 2'b01;
        pc_src            = 2'b01;
        pc_write_cond_raw = 1'b1;
        branch_ne         = (opcode == OP_BNE);
      end
      S_JUMP: begin
        pc_write_raw = 1'b1;
        pc_src       = 2'b10;
      end
      default: ;
    endcase
  end

  // Reset and stall both suppress every write; mux selects are left alone.
  assign en_ok         = rstb & ~stall;
  assign pc_write      = pc_write_raw & en_ok;
  assign pc_write_cond = pc_write_cond_raw & en_ok;
  assign ir_write      = ir_write_raw & en_ok;
  assign mdr_write     = mdr_write_raw & en_ok;
  assign reg_write     = reg_write_raw & en_ok;
  assign mem_wr_ena    = mem_wr_ena_raw & en_ok;
  assign state         = state_q;
  assign halted        = (state_q == S_HALT);

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - randomized bench for multicycle_ctrl_fsm at latencies 1 and 3
module tb_multicycle_ctrl_fsm;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BAD = 6'b111111;

  logic       clk;
  logic       stall_r [2];
  logic       rstb_r [2];
  logic [5:0] opc_r [2];
  wire [21:0] obs0, obs1;

  int checks = 0;
  int errors = 0;
  int ph_st[$];
  bit ph_fin[$];

  multicycle_ctrl_fsm #(.MEM_LATENCY(1), .CNT_W(4)) u_l1 (
    .clk(clk), .rstb(rstb_r[0]), .stall(stall_r[0]), .opcode(opc_r[0]),
    .state(obs0[21:18]), .halted(obs0[17]), .pc_write(obs0[16]), .pc_write_cond(obs0[15]),
    .ir_write(obs0[14]), .mdr_write(obs0[13]), .reg_write(obs0[12]), .mem_wr_ena(obs0[11]),
    .branch_ne(obs0[10]), .alu_src_a(obs0[9]), .alu_src_b(obs0[8:7]), .alu_op(obs0[6:5]),
    .pc_src(obs0[4:3]), .i_or_d(obs0[2]), .reg_dst(obs0[1]), .mem_to_reg(obs0[0])
  );

  multicycle_ctrl_fsm #(.MEM_LATENCY(3), .CNT_W(4)) u_l3 (
    .clk(clk), .rstb(rstb_r[1]), .stall(stall_r[1]), .opcode(opc_r[1]),
    .state(obs1[21:18]), .halted(obs1[17]), .pc_write(obs1[16]), .pc_write_cond(obs1[15]),
    .ir_write(obs1[14]), .mdr_write(obs1[13]), .reg_write(obs1[12]), .mem_wr_ena(obs1[11]),
    .branch_ne(obs1[10]), .alu_src_a(obs1[9]), .alu_src_b(obs1[8:7]), .alu_op(obs1[6:5]),
    .pc_src(obs1[4:3]), .i_or_d(obs1[2]), .reg_dst(obs1[1]), .mem_to_reg(obs1[0])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Instruction length straight from the cycles-per-instruction rules.
  function automatic int exp_cpi(input logic [5:0] op, input int l);
    if (op == OP_LW) return 2 * l + 3;
    if (op == OP_BEQ || op == OP_BNE || op == OP_J) return l + 2;
    return l + 3;
  endfunction

  function automatic logic [21:0] expect_out(input int st, input bit fin, input logic [5:0] op,
                                             input bit stl, input bit rb);
    logic h, pw, pwc, irw, mdw, rw, mw, bne, sa, iod, rd, m2r;
    logic [1:0] sb, ao, ps;
    {h, pw, pwc, irw, mdw, rw, mw, bne, sa, iod, rd, m2r} = '0;
    {sb, ao, ps} = '0;
    case (st)
      0:  begin sb = 2'b01; irw = fin; pw = fin; end
      1:  sb = 2'b11;
      2:  begin sa = 1; ao = 2'b10; end
      4:  begin sa = 1; sb = 2'b10; ao = 2'b11; end
      3:  begin rw = 1; rd = (op == OP_R); end
      5:  begin sa = 1; sb = 2'b10; end
      6:  begin iod = 1; mdw = fin; end
      7:  begin rw = 1; m2r = 1; end
      8:  begin iod = 1; mw = 1; end
      9:  begin sa = 1; ao = 2'b01; ps = 2'b01; pwc = 1; bne = (op == OP_BNE); end
      10: begin pw = 1; ps = 2'b10; end
      15: h = 1;
      default: ;
    endcase
    if (!rb || stl) {pw, pwc, irw, mdw, rw, mw} = '0;
    return {st[3:0], h, pw, pwc, irw, mdw, rw, mw, bne, sa, sb, ao, ps, iod, rd, m2r};
  endfunction

  // Instruction as a list of unstalled cycles: (state, last-wait-cycle flag).
  task automatic build_phases(input logic [5:0] op, input int l);
    ph_st.delete();
    ph_fin.delete();
    for (int i = 0; i < l; i++) begin ph_st.push_back(0); ph_fin.push_back(i == l - 1); end
    ph_st.push_back(1); ph_fin.push_back(0);
    if (op == OP_R) begin
      ph_st.push_back(2); ph_st.push_back(3); ph_fin.push_back(0); ph_fin.push_back(0);
    end else if (op == 6'b001000 || op == 6'b001010 || op == 6'b001100 ||
                 op == 6'b001101 || op == 6'b001110) begin
      ph_st.push_back(4); ph_st.push_back(3); ph_fin.push_back(0); ph_fin.push_back(0);
    end else if (op == OP_LW) begin
      ph_st.push_back(5); ph_fin.push_back(0);
      for (int i = 0; i < l; i++) begin ph_st.push_back(6); ph_fin.push_back(i == l - 1); end
      ph_st.push_back(7); ph_fin.push_back(0);
    end else if (op == OP_SW) begin
      ph_st.push_back(5); ph_st.push_back(8); ph_fin.push_back(0); ph_fin.push_back(0);
    end else if (op == OP_BEQ || op == OP_BNE) begin
      ph_st.push_back(9); ph_fin.push_back(0);
    end else if (op == OP_J) begin
      ph_st.push_back(10); ph_fin.push_back(0);
    end else begin
      ph_st.push_back(15); ph_fin.push_back(0);
    end
  endtask

  task automatic run_instr(input string tag, input int k, input logic [5:0] op, input bit rnd,
                           input int fst, input int fn, output int cyc, output int nst);
    int idx = 0;
    int forced = 0;
    bit st;
    logic [21:0] got, ex;
    cyc = 0;
    nst = 0;
    build_phases(op, lat(k));
    while (idx < ph_st.size() && cyc < 300) begin
      @(negedge clk);
      st = 0;
      if (ph_st[idx] == fst && forced < fn) begin st = 1; forced++; end
      else if (rnd) st = ($urandom_range(0, 3) == 0);
      stall_r[k] = st;
      rstb_r[k] = 1'b1;
      opc_r[k] = op;
      #1;
      got = (k == 0) ? obs0 : obs1;
      ex = expect_out(ph_st[idx], ph_fin[idx], op, st, 1'b1);
      checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL %s dut%0d cycle %0d stall %0d: got %h want %h", tag, k, cyc, st, got, ex);
      end
      cyc++;
      if (st) nst++;
      else idx++;
    end
    checks++;
    if (idx < ph_st.size()) begin
      errors++;
      $display("FAIL %s dut%0d timeout: reached phase %0d want %0d", tag, k, idx, ph_st.size());
    end
    @(negedge clk);
    stall_r[k] = 1'b1;
  endtask

  task automatic check_len(input string tag, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycles: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic test_reset;
    logic [21:0] ex;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        ex = expect_out(0, lat(k) == 1, OP_R, 1'b1, 1'b0);
        checks++;
        if (((k == 0) ? obs0 : obs1) !== ex) begin
          errors++;
          $display("FAIL reset dut%0d: got %h want %h", k, (k == 0) ? obs0 : obs1, ex);
        end
      end
    end
  endtask

  task automatic test_r_type;
    int cyc, nst;
    run_instr("r_type", 0, OP_R, 0, -1, 0, cyc, nst);
    check_len("r_type_len", cyc, 4);
  endtask

  task automatic test_lw_l3;
    int cyc, nst;
    run_instr("lw_l3", 1, OP_LW, 0, -1, 0, cyc, nst);
    check_len("lw_l3_len", cyc, 9);
  endtask

  task automatic test_branch_jump;
    int cyc, nst;
    for (int k = 0; k < 2; k++) begin
      run_instr("bne", k, OP_BNE, 0, -1, 0, cyc, nst);
      check_len("bne_len", cyc, lat(k) + 2);
      run_instr("j", k, OP_J, 0, -1, 0, cyc, nst);
      check_len("j_len", cyc, lat(k) + 2);
      run_instr("beq", k, OP_BEQ, 0, -1, 0, cyc, nst);
      check_len("beq_len", cyc, lat(k) + 2);
    end
  endtask

  task automatic test_stall_memwrite;
    int cyc, nst;
    for (int k = 0; k < 2; k++) begin
      run_instr("stall_sw", k, OP_SW, 0, 8, 2, cyc, nst);
      check_len("stall_sw_len", cyc, lat(k) + 3 + 2);
    end
    run_instr("stall_fetch_end", 1, OP_LW, 0, 0, 0, cyc, nst);
    run_instr("stall_memread", 1, OP_LW, 0, 6, 3, cyc, nst);
    check_len("stall_memread_len", cyc, 9 + 3);
  endtask

  task automatic test_halt;
    int cyc, nst;
    bit st;
    logic [21:0] ex;
    for (int k = 0; k < 2; k++) begin
      run_instr("halt_entry", k, OP_BAD, 1, -1, 0, cyc, nst);
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        st = $urandom_range(0, 1);
        stall_r[k] = st;
        #1;
        ex = expect_out(15, 0, OP_BAD, st, 1'b1);
        checks++;
        if (((k == 0) ? obs0 : obs1) !== ex) begin
          errors++;
          $display("FAIL halt_hold dut%0d c%0d: got %h want %h", k, c, (k == 0) ? obs0 : obs1, ex);
        end
      end
      @(negedge clk);
      rstb_r[k] = 1'b0;
      #1;
      ex = expect_out(15, 0, OP_BAD, 1'b1, 1'b0);
      checks++;
      if (((k == 0) ? obs0 : obs1) !== ex) begin
        errors++;
        $display("FAIL halt_reset dut%0d: got %h want %h", k, (k == 0) ? obs0 : obs1, ex);
      end
      run_instr("after_halt", k, OP_R, 0, -1, 0, cyc, nst);
      check_len("after_halt_len", cyc, lat(k) + 3);
    end
  endtask

  task automatic test_reset_midwait;
    int cyc, nst;
    logic [21:0] ex;
    @(negedge clk);
    stall_r[1] = 1'b0;
    rstb_r[1] = 1'b1;
    opc_r[1] = OP_R;
    #1;
    ex = expect_out(0, 0, OP_R, 1'b0, 1'b1);
    checks++;
    if (obs1 !== ex) begin
      errors++;
      $display("FAIL midwait_first: got %h want %h", obs1, ex);
    end
    @(negedge clk);
    rstb_r[1] = 1'b0;
    #1;
    ex = expect_out(0, 0, OP_R, 1'b0, 1'b0);
    checks++;
    if (obs1 !== ex) begin
      errors++;
      $display("FAIL midwait_reset: got %h want %h", obs1, ex);
    end
    run_instr("midwait_after", 1, OP_R, 0, -1, 0, cyc, nst);
    check_len("midwait_len", cyc, 6);
  endtask

  task automatic test_random;
    logic [5:0] ops [11];
    int cyc, nst, k;
    logic [5:0] op;
    ops = '{6'b000000, 6'b000010, 6'b000100, 6'b000101, 6'b001000, 6'b001010,
            6'b001100, 6'b001101, 6'b001110, 6'b100011, 6'b101011};
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 1);
      op = ops[$urandom_range(0, 10)];
      run_instr("random", k, op, 1, -1, 0, cyc, nst);
      check_len("random_len", cyc, exp_cpi(op, lat(k)) + nst);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      stall_r[k] = 1'b1;
      rstb_r[k] = 1'b0;
      opc_r[k] = OP_R;
    end
    test_reset();
    test_r_type();
    test_lw_l3();
    test_branch_jump();
    test_stall_memwrite();
    test_halt();
    test_reset_midwait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
